scoreboard_fwd_unit: RTL and testbench

Parametrised hazard and forwarding unit for the in-order integer pipeline. It replaces fixed two-stage load-use detection with a register scoreboard that tracks outstanding long-latency writers (multi-cycle loads, mul/div), and it generalises operand bypass to N source operands and M bypass stages. It sits beside the ID and EX stages. It drives the ID stall and the per-operand EX bypass mux selects.

---
 rtl/scoreboard_fwd_unit_pkg.sv | 10 +
 rtl/scoreboard_fwd_unit_fwd_select.sv | 27 ++
 rtl/scoreboard_fwd_unit.sv | 141 ++++++++++++++
 tb/tb_scoreboard_fwd_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/scoreboard_fwd_unit_pkg.sv
// Shared types and constants for the scoreboard/forwarding unit.
package scoreboard_fwd_unit_pkg;

    localparam int unsigned REG_AW_DEF   = 5;
    localparam int unsigned FWD_RF       = 0;
    localparam int unsigned FWD_BYP_BASE = 1;

    typedef logic [REG_AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/scoreboard_fwd_unit_fwd_select.sv
// Single-operand bypass priority matcher; the youngest matching stage wins.
module scoreboard_fwd_unit_fwd_select
    import scoreboard_fwd_unit_pkg::*;
#(
    parameter int unsigned NUM_BYP = 2,
    parameter int unsigned REG_AW  = REG_AW_DEF,
    parameter int unsigned SELW    = $clog2(NUM_BYP + 1)
) (
    input  logic [REG_AW-1:0]         rs,
    input  logic [NUM_BYP*REG_AW-1:0] byp_rd,
    input  logic [NUM_BYP-1:0]        byp_we,
    output logic [SELW-1:0]           sel_c
);

    // Scan oldest to youngest so the youngest match is written last.
    always_comb begin
        sel_c = SELW'(FWD_RF);
        if (rs != '0) begin
            for (int j = int'(NUM_BYP) - 1; j >= 0; j--) begin
                if (byp_we[j] && (byp_rd[j*REG_AW +: REG_AW] == rs)) begin
                    sel_c = SELW'(32'(j) + FWD_BYP_BASE);
                end
            end
        end
    end

endmodule

// File: rtl/scoreboard_fwd_unit.sv
// Register scoreboard for long-latency writers plus N-operand/M-stage bypass selection.
// Optional SCOREBOARD_PERF_EN adds stall_cycles and raw_stalls counters.
module scoreboard_fwd_unit
    import scoreboard_fwd_unit_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned NUM_BYP = 2,
    parameter int unsigned REG_AW  = REG_AW_DEF,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned SELW    = $clog2(NUM_BYP + 1),
    parameter int unsigned CNTW    = $clog2(MAX_OUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_en,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_long,
    input  logic                      flush,
    input  logic                      wb_done,
    input  logic [REG_AW-1:0]         wb_rd,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    input  logic [NUM_BYP*REG_AW-1:0] byp_rd,
    input  logic [NUM_BYP-1:0]        byp_we,
    output logic                      stall,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic [CNTW-1:0]           outstanding
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               raw_stalls
`endif
);

    localparam int unsigned NREG = 2 ** REG_AW;

    logic [NREG-1:0] busy_q, busy_d;
    logic [CNTW-1:0] outstanding_q, outstanding_d;
    logic [NREG-1:0] eff_busy;
    logic            raw_hit, waw_hit, cap_hit;
    logic            issue, set_busy, clr_busy;

    // A same-cycle writeback satisfies readers because the register file writes first.
    always_comb begin
        eff_busy = busy_q;
        if (wb_done) begin
            eff_busy[wb_rd] = 1'b0;
        end
    end

    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (id_rs_en[i] && eff_busy[id_rs[i*REG_AW +: REG_AW]]) begin
                raw_hit = 1'b1;
            end
        end
        waw_hit  = id_regwrite && eff_busy[id_rd];
        cap_hit  = id_long && id_regwrite && (outstanding_q == CNTW'(MAX_OUT)) && !wb_done;
        stall    = id_valid && !flush && (raw_hit || waw_hit || cap_hit);
        issue    = id_valid && !stall && !flush;
        set_busy = issue && id_regwrite && id_long && (id_rd != '0);
        clr_busy = wb_done && (wb_rd != '0) && busy_q[wb_rd];
    end

    // Set is applied after clear so a same-register set/clear leaves the bit set.
    always_comb begin
        busy_d        = busy_q;
        outstanding_d = outstanding_q;
        if (clr_busy) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (set_busy) begin
            busy_d[id_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        case ({set_busy, clr_busy})
            2'b10:   outstanding_d = outstanding_q + CNTW'(1);
            2'b01:   outstanding_d = outstanding_q - CNTW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            outstanding_q <= '0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign outstanding = outstanding_q;

    for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_fwd
        scoreboard_fwd_unit_fwd_select #(
            .NUM_BYP (NUM_BYP),
            .REG_AW  (REG_AW),
            .SELW    (SELW)
        ) u_fwd_select (
            .rs     (ex_rs[i*REG_AW +: REG_AW]),
            .byp_rd (byp_rd),
            .byp_we (byp_we),
            .sel_c  (fwd_sel[i*SELW +: SELW])
        );
    end

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] raw_stalls_q, raw_stalls_d;

    // Saturating event counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        raw_stalls_d   = raw_stalls_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (stall && raw_hit && (raw_stalls_q != 32'hFFFF_FFFF)) begin
            raw_stalls_d = raw_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            raw_stalls_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            raw_stalls_q   <= raw_stalls_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign raw_stalls   = raw_stalls_q;
`endif

endmodule

// File: tb/tb_scoreboard_fwd_unit.sv
// Directed table-driven bench for scoreboard_fwd_unit (default parameters).
module tb_scoreboard_fwd_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_en;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_long;
    logic        flush;
    logic        wb_done;
    logic [4:0]  wb_rd;
    logic [9:0]  ex_rs;
    logic [9:0]  byp_rd;
    logic [1:0]  byp_we;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [2:0]  outstanding;
`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] raw_stalls;
`endif

    scoreboard_fwd_unit dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rs_en    (id_rs_en),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_long     (id_long),
        .flush       (flush),
        .wb_done     (wb_done),
        .wb_rd       (wb_rd),
        .ex_rs       (ex_rs),
        .byp_rd      (byp_rd),
        .byp_we      (byp_we),
        .stall       (stall),
        .fwd_sel     (fwd_sel),
        .outstanding (outstanding)
`ifdef SCOREBOARD_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .raw_stalls  (raw_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       rst;
        logic       vld;
        logic [4:0] rs0, rs1;
        logic [1:0] rs_en;
        logic [4:0] rd;
        logic       rw, lng, fl, wbd;
        logic [4:0] wbr;
        logic [4:0] ex0, ex1, b0, b1;
        logic [1:0] bwe;
        logic       e_stall;
        logic [1:0] e_sel0, e_sel1;
        logic [2:0] e_out;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input string nm, input int r, input int vld, input int rs0, input int rs1,
                       input int en, input int rd, input int rw, input int lng, input int fl,
                       input int wbd, input int wbr, input int ex0, input int ex1, input int b0,
                       input int b1, input int bwe, input int es, input int s0, input int s1,
                       input int eo);
        vec_t v;
        v.nm = nm; v.rst = 1'(r); v.vld = 1'(vld); v.rs0 = 5'(rs0); v.rs1 = 5'(rs1);
        v.rs_en = 2'(en); v.rd = 5'(rd); v.rw = 1'(rw); v.lng = 1'(lng); v.fl = 1'(fl);
        v.wbd = 1'(wbd); v.wbr = 5'(wbr); v.ex0 = 5'(ex0); v.ex1 = 5'(ex1);
        v.b0 = 5'(b0); v.b1 = 5'(b1); v.bwe = 2'(bwe);
        v.e_stall = 1'(es); v.e_sel0 = 2'(s0); v.e_sel1 = 2'(s1); v.e_out = 3'(eo);
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; id_valid = v.vld; id_rs = {v.rs1, v.rs0}; id_rs_en = v.rs_en;
        id_rd = v.rd; id_regwrite = v.rw; id_long = v.lng; flush = v.fl;
        wb_done = v.wbd; wb_rd = v.wbr; ex_rs = {v.ex1, v.ex0};
        byp_rd = {v.b1, v.b0}; byp_we = v.bwe;
    endtask

    initial begin
        vec_t idle;
        idle = '{nm: "idle", default: '0};
        drive(idle);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        //   name          rst vld rs0 rs1 en rd rw lng fl wbd wbr ex0 ex1 b0 b1 bwe  stall s0 s1 out
        add("idle",         0, 0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 0);
        add("issue_ld5",    0, 1,  0,  0, 0,  5, 1, 1, 0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 0);
        add("raw5_a",       0, 1,  5,  0, 1,  6, 1, 0, 0, 0,  0,  0,  0, 0, 0, 0,   1, 0, 0, 1);
        add("raw5_b",       0, 1,  5,  0, 1,  6, 1, 0, 0, 0,  0,  0,  0, 0, 0, 0,   1, 0, 0, 1);
        add("raw5_wb",      0, 1,  5,  0, 1,  6, 1, 0, 0, 1,  5,  0,  0, 0, 0, 0,   0, 0, 0, 1);
        add("after_wb5",    0, 0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 0);
        add("fwd_young",    0, 0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0,  7, 7, 7, 3,   0, 0, 1, 0);
        add("fwd_old",      0, 0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0,  7, 7, 7, 2,   0, 0, 2, 0);
        add("fwd_x0",       0, 0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 3,   0, 0, 0, 0);
        add("fwd_both",     0, 0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  4,  7, 4, 7, 3,   0, 1, 2, 0);
        add("fwd_nowe",     0, 0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  3,  0, 3, 3, 0,   0, 0, 0, 0);
        add("long_x1",      0, 1,  0,  0, 0,  1, 1, 1, 0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 0);
        add("long_x2",      0, 1,  0,  0, 0,  2, 1, 1, 0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 1);
        add("long_x3",      0, 1,  0,  0, 0,  3, 1, 1, 0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 2);
        add("long_x4",      0, 1,  0,  0, 0,  4, 1, 1, 0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 3);
        add("cap_stall",    0, 1,  0,  0, 0, 10, 1, 1, 0, 0,  0,  0,  0, 0, 0, 0,   1, 0, 0, 4);
        add("cap_wb1",      0, 1,  0,  0, 0, 10, 1, 1, 0, 1,  1,  0,  0, 0, 0, 0,   0, 0, 0, 4);
        add("cap_after",    0, 0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 4);
        add("wb2",          0, 0,  0,  0, 0,  0, 0, 0, 0, 1,  2,  0,  0, 0, 0, 0,   0, 0, 0, 4);
        add("wb3",          0, 0,  0,  0, 0,  0, 0, 0, 0, 1,  3,  0,  0, 0, 0, 0,   0, 0, 0, 3);
        add("long_x9",      0, 1,  0,  0, 0,  9, 1, 1, 0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 2);
        add("same_x9",      0, 1,  0,  0, 0,  9, 1, 1, 0, 1,  9,  0,  0, 0, 0, 0,   0, 0, 0, 3);
        add("read_x9",      0, 1,  9,  0, 1,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0,   1, 0, 0, 3);
        add("flush_raw",    0, 1,  9,  0, 1, 11, 1, 1, 1, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 3);
        add("kept_x9",      0, 1,  0,  9, 2,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0,   1, 0, 0, 3);
        add("no_x11",       0, 1, 11,  0, 1,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 3);
        add("waw_x4",       0, 1,  0,  0, 0,  4, 1, 0, 0, 0,  0,  0,  0, 0, 0, 0,   1, 0, 0, 3);
        add("wb_notbusy",   0, 0,  0,  0, 0,  0, 0, 0, 0, 1, 20,  0,  0, 0, 0, 0,   0, 0, 0, 3);
        add("after_nb",     0, 0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 3);
        add("mid_reset",    1, 0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 3);
        add("post_reset",   0, 1,  9,  4, 3,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 0);
        add("long_x0",      0, 1,  0,  0, 0,  0, 1, 1, 0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 0);
        add("read_x0",      0, 1,  0,  0, 3,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 0);

        foreach (vq[k]) begin
            @(negedge clk);
            drive(vq[k]);
            #1;
            chk({vq[k].nm, ".stall"}, 32'(stall), 32'(vq[k].e_stall));
            chk({vq[k].nm, ".sel0"}, 32'(fwd_sel[1:0]), 32'(vq[k].e_sel0));
            chk({vq[k].nm, ".sel1"}, 32'(fwd_sel[3:2]), 32'(vq[k].e_sel1));
            chk({vq[k].nm, ".out"}, 32'(outstanding), 32'(vq[k].e_out));
        end

        // Busy bit becomes visible exactly one cycle after the producer issues.
        @(negedge clk);
        drive(idle);
        id_valid = 1'b1; id_rd = 5'd12; id_regwrite = 1'b1; id_long = 1'b1;
        id_rs = {5'd0, 5'd12}; id_rs_en = 2'b00;
        #1;
        chk("vis.issue_stall", 32'(stall), 32'd0);
        @(negedge clk);
        drive(idle);
        id_valid = 1'b1; id_rs = {5'd12, 5'd0}; id_rs_en = 2'b10;
        #1;
        chk("vis.next_stall", 32'(stall), 32'd1);
        chk("vis.next_out", 32'(outstanding), 32'd1);
        id_valid = 1'b0;
        #1;
        chk("vis.idle_stall", 32'(stall), 32'd0);

        @(negedge clk);
        drive(idle);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
